// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit in front of the word-addressed
//   Ram:
//     - RV32I load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//     - lsu_state_t, the state encoding of the access sequencer
//     - RAM_AW_DEFAULT, the default Ram word-address width
//     - small decode helpers for legality and access size
//   Optional build macro used by the users of this package:
//     LSU_MISALIGN_TRAP_EN - reject misaligned half/word accesses.
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam int RAM_AW_DEFAULT = 14;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_DATA = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_t;

  // Loads accept LB/LH/LW/LBU/LHU; stores accept SB/SH/SW only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Half-word access (signed or unsigned); only meaningful for legal codes.
  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage : lsu_pkg

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational byte-lane logic shared by loads and sub-word stores.
//   Ports:
//     word_i    [31:0] word read from the Ram
//     wdata_i   [31:0] right-aligned store data
//     off_i     [1:0]  byte offset within the word (addr[1:0])
//     funct3_i  [2:0]  RV32I funct3 of the access
//     load_o    [31:0] selected lane, sign- or zero-extended
//     merge_o   [31:0] word_i with the store lane replaced by wdata_i
//   Word accesses ignore off_i; half accesses only look at off_i[1].
// ----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction for loads.
  always_comb begin
    byte_sel = word_i[7:0];
    unique case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Lane insertion for read-modify-write stores. SW never reaches the merge
  // path in practice, but falls back to the raw store data for completeness.
  always_comb begin
    merge_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        merge_o = word_i;
        unique case (off_i)
          2'd0: merge_o[7:0]   = wdata_i[7:0];
          2'd1: merge_o[15:8]  = wdata_i[7:0];
          2'd2: merge_o[23:16] = wdata_i[7:0];
          2'd3: merge_o[31:24] = wdata_i[7:0];
          default: merge_o     = word_i;
        endcase
      end
      F3_H: begin
        merge_o = word_i;
        if (off_i[1]) begin
          merge_o[31:16] = wdata_i[15:0];
        end else begin
          merge_o[15:0]  = wdata_i[15:0];
        end
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule : lsu_lane_align

// File: rtl/lsu_ram_port.sv
// ----------------------------------------------------------------------------
// lsu_ram_port
//   Load/store unit between the rv32i execute stage and a 32-bit word-
//   addressed Ram without byte enables (1-cycle synchronous read).
//   One access in flight at a time; sub-word stores are read-modify-write.
//
//   Parameters:
//     RAM_AW      Ram word-address width (default 14)
//   Ports:
//     clk         system clock, rising edge
//     rst         asynchronous, active-low reset
//     req_valid   core request present
//     req_ready   accepting requests (IDLE only, low while in reset)
//     req_we      1 = store, 0 = load
//     req_funct3  RV32I funct3 of the access
//     req_addr    byte address; [RAM_AW+1:2] is the word, higher bits ignored
//     req_wdata   right-aligned store data
//     resp_valid  one-cycle completion pulse (no backpressure)
//     resp_rdata  extended load data, 0 for stores and errors
//     resp_err    access rejected without touching the Ram
//     ram_ren / ram_raddr                Ram read port
//     ram_wen / ram_waddr / ram_wdata    Ram write port
//     ram_rdata   Ram read data, valid the cycle after ram_ren
//
//   Build option:
//     LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses return
//                           resp_err; otherwise alignment bits are ignored.
//
//   Timing from the accept edge: SW resp at +2, loads +3, SB/SH +4,
//   errors +1. All outputs except req_ready are registered Moore outputs.
// ----------------------------------------------------------------------------
module lsu_ram_port
  import lsu_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [RAM_AW-1:0] ram_raddr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // --------------------------------------------------------------------------
  // State and capture registers
  // --------------------------------------------------------------------------
  lsu_state_t        state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [RAM_AW-1:0] word_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;

  // Registered outputs
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic              ram_ren_q;
  logic              ram_wen_q;
  logic [RAM_AW-1:0] ram_raddr_q;
  logic [RAM_AW-1:0] ram_waddr_q;
  logic [31:0]       ram_wdata_q;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [RAM_AW-1:0] req_word;
  logic              req_legal;
  logic              req_misaligned;
  logic              req_reject;
  logic              req_is_sw;
  logic              unused_addr_hi;

  assign req_word  = req_addr[RAM_AW+1:2];
  assign req_legal = f3_legal(req_we, req_funct3);
  assign req_is_sw = req_we && (req_funct3 == F3_W);

  // Address bits above the Ram window are deliberately ignored.
  assign unused_addr_hi = ^req_addr[31:RAM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = (f3_is_half(req_funct3) && req_addr[0]) ||
                          ((req_funct3 == F3_W) && (req_addr[1:0] != 2'd0));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_reject = !req_legal || req_misaligned;

  // --------------------------------------------------------------------------
  // Lane extraction / merge on the word coming back from the Ram
  // --------------------------------------------------------------------------
  logic [31:0] load_word;
  logic [31:0] merge_word;

  lsu_lane_align u_lane_align (
    .word_i   (ram_rdata),
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  // --------------------------------------------------------------------------
  // Sequencer. Outputs are loaded on the transition into the state that owns
  // them and cleared by default otherwise, so each is high exactly while the
  // owning state is current and its address/data buses read 0 elsewhere.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      word_q       <= '0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_raddr_q  <= '0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_raddr_q  <= '0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= 32'd0;

      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            word_q  <= req_word;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_reject) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_is_sw) begin
              // Full-word store needs no old data: write straight away.
              state_q     <= ST_WR;
              ram_wen_q   <= 1'b1;
              ram_waddr_q <= req_word;
              ram_wdata_q <= req_wdata;
            end else begin
              state_q     <= ST_RD;
              ram_ren_q   <= 1'b1;
              ram_raddr_q <= req_word;
            end
          end
        end

        ST_RD: begin
          // Ram samples the read address at the end of this cycle.
          state_q <= ST_DATA;
        end

        ST_DATA: begin
          if (we_q) begin
            state_q     <= ST_WR;
            ram_wen_q   <= 1'b1;
            ram_waddr_q <= word_q;
            ram_wdata_q <= merge_word;
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_word;
          end
        end

        ST_WR: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is the only decoded output; gating with rst keeps it low for the
  // whole reset window and high in the very first cycle after release.
  assign req_ready  = (state_q == ST_IDLE) && rst;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign ram_ren    = ram_ren_q;
  assign ram_wen    = ram_wen_q;
  assign ram_raddr  = ram_raddr_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule : lsu_ram_port
